// File: rtl/unidade_controle.sv
// Program sequencer/decoder for memoria: fetches opcode+immediate, issues one-cycle datapath strobes,
// and holds opUla through a bounded ALU wait. All outputs registered; strobes are visible during EXECUTA.
module unidade_controle #(
    parameter int ULTIMO_END    = 5,
    parameter int LIMITE_ESPERA = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iniciar,
    input  logic [3:0] insControle,
    input  logic [3:0] inX,
    input  logic       ula_pronto,
    output logic [3:0] count,
    output logic [3:0] dado,
    output logic       limpa,
    output logic       carregaX,
    output logic       carregaY,
    output logic [1:0] opUla,
    output logic       inicia_ula,
    output logic       fim,
    output logic       erro
);

    localparam int CW = $clog2(LIMITE_ESPERA + 1);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        BUSCA   = 3'd1,
        EXECUTA = 3'd2,
        ESPERA  = 3'd3,
        FIM     = 3'd4
    } estado_t;

    estado_t         r_estado;
    estado_t         w_prox;
    logic [3:0]      r_op;
    logic [3:0]      r_count;
    logic [3:0]      r_dado;
    logic            r_limpa;
    logic            r_carregaX;
    logic            r_carregaY;
    logic [1:0]      r_opUla;
    logic            r_inicia_ula;
    logic            r_fim;
    logic            r_erro;
    logic [CW-1:0]   r_espera;

    logic [3:0]      w_op;
    logic [3:0]      w_count;
    logic [3:0]      w_dado;
    logic            w_limpa;
    logic            w_carregaX;
    logic            w_carregaY;
    logic [1:0]      w_opUla;
    logic            w_inicia_ula;
    logic            w_fim;
    logic            w_erro;
    logic [CW-1:0]   w_espera;

    logic            w_ultimo;
    logic            w_limite;

    assign w_ultimo = (r_count == 4'(ULTIMO_END));
    assign w_limite = (r_espera == CW'(LIMITE_ESPERA - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox;
        end
    end

    always_comb begin
        w_prox = r_estado;
        unique case (r_estado)
            OCIOSO:  if (iniciar) w_prox = BUSCA;
            BUSCA:   w_prox = EXECUTA;
            EXECUTA: begin
                case (r_op)
                    4'd0, 4'd1, 4'd2: w_prox = w_ultimo ? FIM : BUSCA;
                    4'd3, 4'd4:       w_prox = ESPERA;
                    default:          w_prox = FIM;
                endcase
            end
            ESPERA: begin
                if (ula_pronto)    w_prox = w_ultimo ? FIM : BUSCA;
                else if (w_limite) w_prox = FIM;
            end
            FIM:     if (iniciar) w_prox = BUSCA;
            default: w_prox = OCIOSO;
        endcase
    end

    // Strobes are computed from the opcode as it is fetched so that, once registered,
    // they line up with the EXECUTA cycle of that same instruction.
    always_comb begin
        w_op         = r_op;
        w_count      = r_count;
        w_dado       = r_dado;
        w_limpa      = 1'b0;
        w_carregaX   = 1'b0;
        w_carregaY   = 1'b0;
        w_opUla      = 2'b00;
        w_inicia_ula = 1'b0;
        w_fim        = r_fim;
        w_erro       = r_erro;
        w_espera     = '0;
        unique case (r_estado)
            OCIOSO: begin
                if (iniciar) begin
                    w_count = 4'd0;
                    w_fim   = 1'b0;
                    w_erro  = 1'b0;
                end
            end
            BUSCA: begin
                w_op   = insControle;
                w_dado = inX;
                case (insControle)
                    4'd0: w_limpa    = 1'b1;
                    4'd1: w_carregaX = 1'b1;
                    4'd2: w_carregaY = 1'b1;
                    4'd3: begin
                        w_opUla      = 2'b01;
                        w_inicia_ula = 1'b1;
                    end
                    4'd4: begin
                        w_opUla      = 2'b10;
                        w_inicia_ula = 1'b1;
                    end
                    default: ;
                endcase
            end
            EXECUTA: begin
                case (r_op)
                    4'd0, 4'd1, 4'd2: begin
                        if (w_ultimo) w_fim   = 1'b1;
                        else          w_count = r_count + 4'd1;
                    end
                    4'd3, 4'd4: w_opUla = r_opUla;
                    4'd5:       w_fim   = 1'b1;
                    default: begin
                        w_erro = 1'b1;
                        w_fim  = 1'b1;
                    end
                endcase
            end
            ESPERA: begin
                if (ula_pronto) begin
                    if (w_ultimo) w_fim   = 1'b1;
                    else          w_count = r_count + 4'd1;
                end else if (w_limite) begin
                    w_erro = 1'b1;
                    w_fim  = 1'b1;
                end else begin
                    w_opUla  = r_opUla;
                    w_espera = r_espera + CW'(1);
                end
            end
            FIM: begin
                if (iniciar) begin
                    w_count = 4'd0;
                    w_fim   = 1'b0;
                    w_erro  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= 4'd0;
            r_count      <= 4'd0;
            r_dado       <= 4'd0;
            r_limpa      <= 1'b0;
            r_carregaX   <= 1'b0;
            r_carregaY   <= 1'b0;
            r_opUla      <= 2'b00;
            r_inicia_ula <= 1'b0;
            r_fim        <= 1'b0;
            r_erro       <= 1'b0;
            r_espera     <= '0;
        end else begin
            r_op         <= w_op;
            r_count      <= w_count;
            r_dado       <= w_dado;
            r_limpa      <= w_limpa;
            r_carregaX   <= w_carregaX;
            r_carregaY   <= w_carregaY;
            r_opUla      <= w_opUla;
            r_inicia_ula <= w_inicia_ula;
            r_fim        <= w_fim;
            r_erro       <= w_erro;
            r_espera     <= w_espera;
        end
    end

    assign count      = r_count;
    assign dado       = r_dado;
    assign limpa      = r_limpa;
    assign carregaX   = r_carregaX;
    assign carregaY   = r_carregaY;
    assign opUla      = r_opUla;
    assign inicia_ula = r_inicia_ula;
    assign fim        = r_fim;
    assign erro       = r_erro;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: program memory and ALU responder models, strobe scoreboard.
module tb_unidade_controle;

    logic       clk;
    logic       rst_n;
    logic       iniciar;
    logic [3:0] insControle;
    logic [3:0] inX;
    logic       ula_pronto;
    logic [3:0] count;
    logic [3:0] dado;
    logic       limpa;
    logic       carregaX;
    logic       carregaY;
    logic [1:0] opUla;
    logic       inicia_ula;
    logic       fim;
    logic       erro;

    logic       iniciar2;
    logic [3:0] ins2;
    logic [3:0] x2;
    logic       ula_pronto2;
    logic [3:0] count2;
    logic [3:0] dado2;
    logic       limpa2;
    logic       carregaX2;
    logic       carregaY2;
    logic [1:0] opUla2;
    logic       inicia2;
    logic       fim2;
    logic       erro2;

    logic [3:0] mem_op [16];
    logic [3:0] mem_x  [16];
    logic [3:0] mem2_op[16];

    int n_checks = 0;
    int n_errors = 0;
    int ula_delay = 0;
    int pend = 0;
    logic [13:0] sb[$];

    unidade_controle #(.ULTIMO_END(5), .LIMITE_ESPERA(15)) dut (
        .clk(clk), .rst_n(rst_n), .iniciar(iniciar), .insControle(insControle), .inX(inX),
        .ula_pronto(ula_pronto), .count(count), .dado(dado), .limpa(limpa), .carregaX(carregaX),
        .carregaY(carregaY), .opUla(opUla), .inicia_ula(inicia_ula), .fim(fim), .erro(erro)
    );

    unidade_controle #(.ULTIMO_END(2), .LIMITE_ESPERA(15)) dut2 (
        .clk(clk), .rst_n(rst_n), .iniciar(iniciar2), .insControle(ins2), .inX(x2),
        .ula_pronto(ula_pronto2), .count(count2), .dado(dado2), .limpa(limpa2), .carregaX(carregaX2),
        .carregaY(carregaY2), .opUla(opUla2), .inicia_ula(inicia2), .fim(fim2), .erro(erro2)
    );

    assign insControle = mem_op[count];
    assign inX         = mem_x[count];
    assign ins2        = mem2_op[count2];
    assign x2          = 4'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] ev(input logic [3:0] kind, input logic [3:0] c,
                                       input logic [3:0] d, input logic [1:0] op);
        return {kind, c, d, op};
    endfunction

    task automatic set_prog(input logic [63:0] ops, input logic [63:0] xs);
        for (int i = 0; i < 16; i++) begin
            mem_op[i] = ops[4*i +: 4];
            mem_x[i]  = xs[4*i +: 4];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ALU model: ula_pronto pulses ula_delay cycles after the inicia_ula cycle (0 = never)
    always @(negedge clk) begin
        ula_pronto = 1'b0;
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) ula_pronto = 1'b1;
            end
            if (inicia_ula && ula_delay > 0) pend = ula_delay;
        end
    end

    always @(negedge clk) begin
        logic [13:0] obs;
        if (rst_n && (limpa || carregaX || carregaY || inicia_ula)) begin
            obs = {limpa, carregaX, carregaY, inicia_ula, count, dado, opUla};
            if (sb.size() == 0) chk("unexpected_strobe", 32'(obs), 32'd0);
            else                chk("strobe", 32'(obs), 32'(sb.pop_front()));
        end
    end

    initial begin
        int first_fim;
        int n01;
        int n10;
        int max2;
        rst_n       = 1'b0;
        iniciar     = 1'b0;
        iniciar2    = 1'b0;
        ula_pronto2 = 1'b0;
        set_prog(64'hFFFF_FFFF_FF54_3210, 64'h0000_0000_0000_0530);
        for (int i = 0; i < 16; i++) mem2_op[i] = 4'hF;
        mem2_op[0] = 4'd0; mem2_op[1] = 4'd1; mem2_op[2] = 4'd2; mem2_op[3] = 4'd1;

        tick(); tick();
        chk("reset_outputs", {count, dado, limpa, carregaX, carregaY, opUla, inicia_ula, fim, erro}, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_after_reset", {count, fim, erro, opUla}, 0);

        // Default program, ALU answers two cycles after the start pulse
        ula_delay = 2;
        sb.push_back(ev(4'b1000, 4'd0, 4'd0, 2'b00));
        sb.push_back(ev(4'b0100, 4'd1, 4'd3, 2'b00));
        sb.push_back(ev(4'b0010, 4'd2, 4'd5, 2'b00));
        sb.push_back(ev(4'b0001, 4'd3, 4'd0, 2'b01));
        sb.push_back(ev(4'b0001, 4'd4, 4'd0, 2'b10));
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        first_fim = -1; n01 = 0; n10 = 0;
        for (int c = 0; c < 20; c++) begin
            if (fim && first_fim < 0) first_fim = c;
            if (opUla == 2'b01) n01++;
            if (opUla == 2'b10) n10++;
            tick();
        end
        chk("t1_run_length", first_fim, 16);
        chk("t1_add_hold", n01, 3);
        chk("t1_sub_hold", n10, 3);
        chk("t1_final", {fim, erro, count}, {1'b1, 1'b0, 4'd5});

        // Illegal opcode at address 2
        set_prog(64'hFFFF_FFFF_FFFF_FA21, 64'h0000_0000_0000_0097);
        sb.push_back(ev(4'b0100, 4'd0, 4'd7, 2'b00));
        sb.push_back(ev(4'b0010, 4'd1, 4'd9, 2'b00));
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("t2_restart", {fim, erro, count}, 0);
        repeat (4) tick();
        chk("t2_fetch_addr2", {fim, erro, count}, {1'b0, 1'b0, 4'd2});
        tick();
        chk("t2_execute", {fim, erro}, 0);
        tick();
        chk("t2_illegal", {fim, erro, count}, {1'b1, 1'b1, 4'd2});
        repeat (3) tick();
        chk("t2_frozen", {fim, erro, count}, {1'b1, 1'b1, 4'd2});

        // ADD with the ALU never answering
        set_prog(64'hFFFF_FFFF_FFFF_FFF3, 64'h0000_0000_0000_0004);
        ula_delay = 0;
        sb.push_back(ev(4'b0001, 4'd0, 4'd4, 2'b01));
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("t3_restart_clears", {fim, erro}, 0);
        repeat (16) tick();
        chk("t3_last_wait", {fim, erro, opUla}, {1'b0, 1'b0, 2'b01});
        tick();
        chk("t3_timeout", {fim, erro, opUla}, {1'b1, 1'b1, 2'b00});

        // ALU answers on the 15th wait cycle
        set_prog(64'hFFFF_FFFF_FFF5_3210, 64'h0000_0000_0000_6321);
        ula_delay = 15;
        sb.push_back(ev(4'b1000, 4'd0, 4'd1, 2'b00));
        sb.push_back(ev(4'b0100, 4'd1, 4'd2, 2'b00));
        sb.push_back(ev(4'b0010, 4'd2, 4'd3, 2'b00));
        sb.push_back(ev(4'b0001, 4'd3, 4'd6, 2'b01));
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("t3_busca_after_restart", {count, fim, erro}, 0);
        repeat (22) tick();
        chk("t4_wait15", {erro, opUla, count}, {1'b0, 2'b01, 4'd3});
        tick();
        chk("t4_advance", {fim, erro, opUla, count}, {1'b0, 1'b0, 2'b00, 4'd4});
        repeat (2) tick();
        chk("t4_halt", {fim, erro, count}, {1'b1, 1'b0, 4'd4});

        // iniciar ignored in EXECUTA, then async reset during ESPERA
        set_prog(64'hFFFF_FFFF_FFFF_FF31, 64'h0000_0000_0000_0028);
        ula_delay = 0;
        sb.push_back(ev(4'b0100, 4'd0, 4'd8, 2'b00));
        sb.push_back(ev(4'b0001, 4'd1, 4'd2, 2'b01));
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("t5_iniciar_ignored", count, 4'd1);
        repeat (4) tick();
        chk("t5_in_espera", {opUla, count}, {2'b01, 4'd1});
        rst_n = 1'b0;
        #1;
        chk("t5_async_reset", {count, dado, limpa, carregaX, carregaY, opUla, inicia_ula, fim, erro}, 0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("t5_idle_after_reset", {count, fim, erro, opUla}, 0);

        // Shorter program space without HLT
        iniciar2 = 1'b1;
        tick();
        iniciar2 = 1'b0;
        max2 = 0;
        repeat (5) begin
            tick();
            if (int'(count2) > max2) max2 = int'(count2);
        end
        chk("t6_ldy_last", {carregaY2, fim2, count2}, {1'b1, 1'b0, 4'd2});
        tick();
        chk("t6_fim", {fim2, erro2, count2}, {1'b1, 1'b0, 4'd2});
        repeat (3) begin
            tick();
            if (int'(count2) > max2) max2 = int'(count2);
        end
        chk("t6_no_wrap", max2, 2);
        chk("t6_held", {fim2, count2}, {1'b1, 4'd2});

        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
Sequencer and decoder that sits directly upstream of and around the instruction memory (memoria). It drives the program address `count` and samples the returned `insControle`/`inX` pair. It decodes each instruction into one-cycle load/clear strobes and a multi-cycle ALU handshake toward the datapath. It runs a program from address 0 on `iniciar` until HLT, the last address, an illegal opcode, or an ALU timeout.

Parameters:
ULTIMO_END, 5, last valid program address; execution ends after this address even without HLT.
LIMITE_ESPERA, 15, maximum ESPERA cycles allowed before `ula_pronto` is declared lost.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
iniciar  in  1  start request; honoured only in OCIOSO or FIM
insControle  in  4  opcode from memoria (combinational from count)
inX  in  4  immediate from memoria
ula_pronto  in  1  datapath ALU result valid; sampled only in ESPERA
count  out  4  program address to memoria
dado  out  4  latched immediate for the datapath
limpa  out  1  clear-all strobe
carregaX  out  1  load X register from dado
carregaY  out  1  load Y register from dado
opUla  out  2  00 none, 01 add, 10 sub
inicia_ula  out  1  ALU start pulse
fim  out  1  program finished (level)
erro  out  1  illegal opcode or ALU timeout (sticky until restart/reset)

Behaviour:
- Reset (async, rst_n=0): state OCIOSO; count=0, dado=0, limpa=carregaX=carregaY=inicia_ula=0, opUla=00, fim=0, erro=0, wait counter=0. Reset mid-instruction aborts immediately, including during ESPERA.
- All outputs are registered.
- States are OCIOSO, BUSCA, EXECUTA, ESPERA, FIM.
- OCIOSO: on iniciar=1, count<=0 and go to BUSCA.
- BUSCA (1 cycle): latch insControle into an internal opcode register and inX into dado. Go to EXECUTA.
- EXECUTA (1 cycle), decoded from the latched opcode:
  - 0 CLR: limpa=1.
  - 1 LDX: carregaX=1.
  - 2 LDY: carregaY=1.
  - 3 ADD: opUla=01, inicia_ula=1, go to ESPERA.
  - 4 SUB: opUla=10, inicia_ula=1, go to ESPERA.
  - 5 HLT: go to FIM, fim=1.
  - 6..15: erro=1, go to FIM, fim=1.
- Instructions other than ADD/SUB/HLT/illegal: if count==ULTIMO_END, go to FIM with fim=1; else count<=count+1 and go to BUSCA. These take 2 cycles each.
- ESPERA:
  - opUla is held at its EXECUTA value; inicia_ula=0.
  - The wait counter increments each cycle.
  - On ula_pronto=1: opUla<=00, clear the wait counter, then advance or finish using the same count rule as above.
  - If the counter reaches LIMITE_ESPERA with ula_pronto=0: erro=1, opUla<=00, go to FIM.
  - If ula_pronto=1 arrives in the same cycle the limit is reached, ula_pronto wins (no erro).
- FIM: fim=1 held and count frozen. iniciar=1 clears fim, erro and count, then goes to BUSCA.
- iniciar is ignored in BUSCA, EXECUTA and ESPERA. ula_pronto is ignored outside ESPERA.
- count never wraps: the ULTIMO_END check prevents increment past the last address.
- Strobes are exactly one cycle wide and mutually exclusive.

Test Plan:
1. Default program (opcodes 0..5 at addresses 0..5; inX 0,3,5,0,0,0), with ula_pronto returned 2 cycles after each inicia_ula:
   - limpa at address 0.
   - carregaX with dado=3.
   - carregaY with dado=5.
   - opUla=01 then 10, each held 3 cycles.
   - fim=1 with count=5 and erro=0.
   - Run length is 16 cycles from BUSCA of address 0 to FIM.
2. Illegal opcode 4'b1010 at address 2: erro=1 and fim=1 two cycles after address 2 is fetched; count stays 2; no strobes issued.
3. ADD with ula_pronto never asserted: erro=1 and opUla=00 after 15 ESPERA cycles; then iniciar=1 clears erro/fim and the next cycle shows count=0 in BUSCA.
4. ula_pronto asserted exactly on the 15th ESPERA cycle: no erro; count advances to 4.
5. rst_n pulled low mid-ESPERA: all outputs return to reset values asynchronously, before the next clock edge. iniciar pulsed during EXECUTA is ignored, with no count reset.
6. ULTIMO_END=2 with a program lacking HLT: fim=1 after LDY; count=2, never 3.
